// File: rtl/pattern_generator_multi.sv
// Registered multi-mode VGA test pattern source (vbars, hbars, checker, scrolling bars).
// Optional macro PATTERN_BORDER_EN forces a white 1-pixel frame border over every mode.
module pattern_generator_multi #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int NUM_BARS     = 3,
    parameter int CHECKER_LOG2 = 5,
    parameter int SCROLL_DIV   = 2
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        display_enable,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        frame_start,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    output logic [7:0]  color_out_332,
    output logic [1:0]  mode_active,
    output logic [15:0] frame_count
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / NUM_BARS);
    localparam logic [10:0] BAR_H  = 11'(V_ACTIVE / NUM_BARS);
    localparam logic [9:0]  SCROLL_LAST = 10'(H_ACTIVE - 1);
    localparam int          DIV_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        M_VBARS   = 2'd0,
        M_HBARS   = 2'd1,
        M_CHECKER = 2'd2,
        M_SCROLL  = 2'd3
    } mode_t;

    logic [7:0]       color_q, color_d;
    logic [1:0]       mode_active_q, mode_active_d;
    logic [1:0]       pending_q, pending_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [9:0]       scroll_pos_q, scroll_pos_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [1:0]  render_mode;
    logic [10:0] x11, y11, sum11, sx11;

    // Threshold compare instead of a divider; the last bar absorbs the remainder.
    function automatic logic [2:0] bar_idx(input logic [10:0] c, input logic [10:0] w);
        logic [2:0]  idx;
        logic [10:0] thr;
        idx = 3'd0;
        thr = w;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (c >= thr) idx = idx + 3'd1;
            thr = thr + w;
        end
        return idx;
    endfunction

    function automatic logic [7:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    return 8'hE0;
            3'd1:    return 8'h1C;
            3'd2:    return 8'h03;
            3'd3:    return 8'hFF;
            3'd4:    return 8'hFC;
            3'd5:    return 8'h1F;
            3'd6:    return 8'hE3;
            default: return 8'h92;
        endcase
    endfunction

    always_comb begin
        pending_d   = mode_req ? mode_sel : pending_q;
        // The frame's first pixel already renders in the newly committed mode.
        render_mode = frame_start ? pending_d : mode_active_q;

        x11   = {1'b0, pixel_x};
        y11   = {1'b0, pixel_y};
        sum11 = x11 + {1'b0, scroll_pos_q};
        sx11  = (sum11 >= H_LIM) ? (sum11 - H_LIM) : sum11;

        color_d = 8'h00;
        if (display_enable && (x11 < H_LIM) && (y11 < V_LIM)) begin
            case (mode_t'(render_mode))
                M_VBARS:   color_d = palette(bar_idx(x11, BAR_W));
                M_HBARS:   color_d = palette(bar_idx(y11, BAR_H));
                M_CHECKER: color_d = (pixel_x[CHECKER_LOG2] ^ pixel_y[CHECKER_LOG2]) ? 8'hFF : 8'h00;
                M_SCROLL:  color_d = palette(bar_idx(sx11, BAR_W));
                default:   color_d = 8'h00;
            endcase
        end
`ifdef PATTERN_BORDER_EN
        if (display_enable && ((x11 == 11'd0) || (x11 == H_LIM - 11'd1) ||
                               (y11 == 11'd0) || (y11 == V_LIM - 11'd1)))
            color_d = 8'hFF;
`endif

        mode_active_d = frame_start ? pending_d : mode_active_q;
        frame_count_d = frame_count_q;
        div_d         = div_q;
        scroll_pos_d  = scroll_pos_q;
        if (frame_start) begin
            frame_count_d = frame_count_q + 16'd1;
            if (div_q == DIV_LAST) begin
                div_d        = '0;
                scroll_pos_d = (scroll_pos_q == SCROLL_LAST) ? 10'd0 : scroll_pos_q + 10'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            color_q       <= 8'h00;
            mode_active_q <= 2'd0;
            pending_q     <= 2'd0;
            frame_count_q <= 16'd0;
            scroll_pos_q  <= 10'd0;
            div_q         <= '0;
        end else begin
            color_q       <= color_d;
            mode_active_q <= mode_active_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            scroll_pos_q  <= scroll_pos_d;
            div_q         <= div_d;
        end
    end

    assign color_out_332 = color_q;
    assign mode_active   = mode_active_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_pattern_generator_multi.sv
// Randomised bench for pattern_generator_multi: a frame-count based reference model
// checks two instances (3 bars and 8 bars) every cycle, plus literal spot checks.
module tb_pattern_generator_multi;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int SDIV = 2;
`ifdef PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0, display_enable = 1'b0, frame_start = 1'b0, mode_req = 1'b0;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic [1:0]  mode_sel = '0;
    logic [7:0]  col3, col8;
    logic [1:0]  act3, act8;
    logic [15:0] fc3, fc8;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: committed/pending mode and frames seen since reset.
    int m_pend = 0, m_act = 0, m_frames = 0;
    logic [7:0] pal [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hFC, 8'h1F, 8'hE3, 8'h92};

    always #5 clk = ~clk;

    pattern_generator_multi #(.NUM_BARS(3)) u_dut3 (
        .pixel_clk(clk), .reset(reset), .display_enable(display_enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .mode_sel(mode_sel), .mode_req(mode_req), .color_out_332(col3),
        .mode_active(act3), .frame_count(fc3));

    pattern_generator_multi #(.NUM_BARS(8)) u_dut8 (
        .pixel_clk(clk), .reset(reset), .display_enable(display_enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .mode_sel(mode_sel), .mode_req(mode_req), .color_out_332(col8),
        .mode_active(act8), .frame_count(fc8));

    function automatic bit on_edge(input int x, input int y);
        return (x == 0) || (x == HA - 1) || (y == 0) || (y == VA - 1);
    endfunction

    function automatic logic [7:0] exp_col(input int mode, input int x, input int y,
                                           input bit de, input int scroll, input int nb);
        int b;
        if (!de) return 8'h00;
        if (BORDER && on_edge(x, y)) return 8'hFF;
        if (x >= HA || y >= VA) return 8'h00;
        case (mode)
            0: b = x / (HA / nb);
            1: b = y / (VA / nb);
            2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
            default: b = ((x + scroll) % HA) / (HA / nb);
        endcase
        if (b > nb - 1) b = nb - 1;
        return pal[b];
    endfunction

    // Literal expectation, except that the border overrides edge pixels when enabled.
    function automatic logic [7:0] lit(input int x, input int y, input logic [7:0] v);
        return (BORDER && on_edge(x, y)) ? 8'hFF : v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit de, input int x, input int y,
                       input bit fs, input int sel, input bit req);
        logic [7:0] e3, e8;
        int pe, rm, sc;
        reset = rst; display_enable = de; pixel_x = 10'(x); pixel_y = 10'(y);
        frame_start = fs; mode_sel = 2'(sel); mode_req = req;
        pe = req ? sel : m_pend;
        rm = fs ? pe : m_act;
        sc = (m_frames / SDIV) % HA;
        e3 = rst ? 8'h00 : exp_col(rm, x, y, de, sc, 3);
        e8 = rst ? 8'h00 : exp_col(rm, x, y, de, sc, 8);
        if (rst) begin
            m_pend = 0; m_act = 0; m_frames = 0;
        end else begin
            m_pend = pe;
            if (fs) begin
                m_act = pe;
                m_frames++;
            end
        end
        @(posedge clk);
        #1;
        chk("color3", 16'(col3), 16'(e3));
        chk("color8", 16'(col8), 16'(e8));
        chk("mode_active3", 16'(act3), 16'(m_act));
        chk("mode_active8", 16'(act8), 16'(m_act));
        chk("frame_count3", fc3, 16'(m_frames % 65536));
        chk("frame_count8", fc8, 16'(m_frames % 65536));
    endtask

    initial begin
        int xs [6] = '{0, 212, 213, 425, 426, 639};
        logic [7:0] vb [6] = '{8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h03, 8'h03};
        int ys [4] = '{0, 59, 60, 479};
        logic [7:0] hb [4] = '{8'hE0, 8'hE0, 8'h1C, 8'h92};

        // Reset state
        cyc(1, 1, 100, 100, 0, 0, 0);
        chk("reset color", 16'(col3), 16'h0000);
        chk("reset mode", 16'(act3), 16'h0000);
        chk("reset fcount", fc3, 16'h0000);

        // Vertical bars, default geometry
        foreach (xs[i]) begin
            cyc(0, 1, xs[i], 100, 0, 0, 0);
            chk($sformatf("vbar x=%0d", xs[i]), 16'(col3), 16'(lit(xs[i], 100, vb[i])));
        end
        cyc(0, 0, 300, 100, 0, 0, 0);
        chk("blank de=0", 16'(col3), 16'h0000);

        // Horizontal bars: request and frame start in the same cycle
        cyc(0, 1, 5, 0, 1, 1, 1);
        chk("hbar same-cycle req", 16'(col8), 16'(lit(5, 0, 8'hE0)));
        foreach (ys[i]) begin
            cyc(0, 1, 5, ys[i], 0, 0, 0);
            chk($sformatf("hbar8 y=%0d", ys[i]), 16'(col8), 16'(lit(5, ys[i], hb[i])));
        end
        cyc(0, 1, 700, 100, 0, 0, 0);
        chk("blank x=700", 16'(col3), 16'h0000);

        // Mid-frame request is deferred; last request in a frame wins
        cyc(0, 1, 50, 50, 0, 2, 1);
        chk("deferred mode", 16'(act3), 16'h0001);
        cyc(0, 1, 50, 51, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 2, 1);
        chk("checker at (0,0)", 16'(col3), 16'(lit(0, 0, 8'h00)));
        chk("mode now checker", 16'(act3), 16'h0002);
        cyc(0, 1, 32, 0, 0, 0, 0);
        chk("checker (32,0)", 16'(col3), 16'(lit(32, 0, 8'hFF)));
        cyc(0, 1, 32, 32, 0, 0, 0);
        chk("checker (32,32)", 16'(col3), 16'h0000);
        cyc(0, 1, 31, 33, 0, 0, 0);
        chk("checker (31,33)", 16'(col3), 16'h00FF);

        // Scroll: four frames advance scroll by two pixels
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("fcount after 4", fc3, 16'd4);
        cyc(0, 1, 211, 10, 0, 0, 0);
        chk("scroll x=211", 16'(col3), 16'h001C);

        // Full wrap: 1280 frames bring scroll back to zero
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 1279; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("fcount after 1280", fc3, 16'd1280);
        cyc(0, 1, 212, 10, 0, 0, 0);
        chk("scroll wrap x=212", 16'(col3), 16'h00E0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            int x, y;
            x = ($urandom_range(0, 9) == 0) ? 639 : $urandom_range(0, 720);
            y = ($urandom_range(0, 9) == 0) ? 479 : $urandom_range(0, 500);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, x, y,
                $urandom_range(0, 29) == 0, $urandom_range(0, 3), $urandom_range(0, 19) == 0);
        end

        // Reset during active video, then resume in mode 0 with no frame start
        cyc(0, 1, 0, 0, 1, 2, 1);
        cyc(1, 1, 300, 200, 0, 0, 0);
        chk("mid reset color", 16'(col3), 16'h0000);
        chk("mid reset mode", 16'(act3), 16'h0000);
        chk("mid reset fcount", fc3, 16'h0000);
        cyc(0, 1, 300, 200, 0, 0, 0);
        chk("resume vbars", 16'(col3), 16'h001C);
        cyc(0, 1, 639, 100, 0, 0, 0);
        chk("right edge pixel", 16'(col3), 16'(BORDER ? 8'hFF : 8'h03));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
